// File: rtl/processor_regfile_pkg.sv
// Shared processor definitions: opcode constants, register file defaults and debug FSM states.
package processor_regfile_pkg;

  // Default register address width; the register count is 2**DEFAULT_REG_ADDR_BITS.
  localparam int unsigned DEFAULT_REG_ADDR_BITS = 3;

  // Instruction opcodes.
  localparam logic [3:0] OP_ALU    = 4'h0;
  localparam logic [3:0] OP_ALUI   = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_JUMP   = 4'h5;

  // ALU operation selects.
  localparam logic [2:0] ALU_OP_ADD = 3'h0;
  localparam logic [2:0] ALU_OP_SUB = 3'h1;
  localparam logic [2:0] ALU_OP_AND = 3'h2;
  localparam logic [2:0] ALU_OP_OR  = 3'h3;
  localparam logic [2:0] ALU_OP_XOR = 3'h4;
  localparam logic [2:0] ALU_OP_SHL = 3'h5;
  localparam logic [2:0] ALU_OP_SHR = 3'h6;

  // Debug access port sequencing.
  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_ACCESS,
    DBG_DONE,
    DBG_HOLD
  } dbg_state_e;

endpackage

// File: rtl/processor_regfile_dbg.sv
// Debug access FSM: sequences one read or write per request and produces a single ack pulse.
// Writes are deferred while the pipeline write port is busy; the pipeline always wins.
module processor_regfile_dbg
  import processor_regfile_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 18,
  parameter int unsigned REG_ADDR_BITS = DEFAULT_REG_ADDR_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0]     dbg_wdata,
  input  logic                     pipe_write_enable,
  input  logic [WORD_SIZE-1:0]     read_value,
  output logic                     dbg_ack,
  output logic [WORD_SIZE-1:0]     dbg_rdata,
  output logic                     commit_enable,
  output logic [REG_ADDR_BITS-1:0] commit_addr,
  output logic [WORD_SIZE-1:0]     commit_data
);

  dbg_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  // Next-state, read capture and write commit decisions.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    commit_enable = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (dbg_req) state_d = DBG_ACCESS;
      end
      DBG_ACCESS: begin
        if (!dbg_we) begin
          // read_value already carries any same-cycle pipeline write to dbg_addr
          rdata_d = read_value;
          state_d = DBG_DONE;
        end else if (!pipe_write_enable) begin
          commit_enable = 1'b1;
          state_d       = DBG_DONE;
        end
      end
      DBG_DONE: begin
        state_d = dbg_req ? DBG_HOLD : DBG_IDLE;
      end
      DBG_HOLD: begin
        if (!dbg_req) state_d = DBG_IDLE;
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  // State and read-result registers; reset aborts any access in flight without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DBG_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbg_ack     = (state_q == DBG_DONE);
  assign dbg_rdata   = rdata_q;
  assign commit_addr = dbg_addr;
  assign commit_data = dbg_wdata;

endmodule

// File: rtl/processor_regfile.sv
// General-purpose register file: one merged write port (pipeline or debug), two registered
// read ports with write-to-read bypass, and a handshaked debug access port.
module processor_regfile
  import processor_regfile_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 18,
  parameter int unsigned REG_ADDR_BITS = DEFAULT_REG_ADDR_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reg_write_enable,
  input  logic [REG_ADDR_BITS-1:0] reg_write_addr,
  input  logic [WORD_SIZE-1:0]     reg_write_data,
  input  logic                     read_stall,
  input  logic [REG_ADDR_BITS-1:0] read_addr0,
  input  logic [REG_ADDR_BITS-1:0] read_addr1,
  output logic [WORD_SIZE-1:0]     read_data0,
  output logic [WORD_SIZE-1:0]     read_data1,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0]     dbg_wdata,
  output logic                     dbg_ack,
  output logic [WORD_SIZE-1:0]     dbg_rdata
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_BITS;

  logic [WORD_SIZE-1:0]     regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]     read_data0_q, read_data1_q;

  logic                     dbg_commit_enable;
  logic [REG_ADDR_BITS-1:0] dbg_commit_addr;
  logic [WORD_SIZE-1:0]     dbg_commit_data;

  logic                     wr_enable;
  logic [REG_ADDR_BITS-1:0] wr_addr;
  logic [WORD_SIZE-1:0]     wr_data;
  logic [WORD_SIZE-1:0]     rd0_value, rd1_value, dbg_read_value;

  // Merge the two write sources; the debug FSM only commits when the pipeline is idle.
  always_comb begin
    wr_enable = reg_write_enable | dbg_commit_enable;
    wr_addr   = reg_write_enable ? reg_write_addr : dbg_commit_addr;
    wr_data   = reg_write_enable ? reg_write_data : dbg_commit_data;
  end

  // Bypassed read values for both read ports and the debug read.
  always_comb begin
    rd0_value = (wr_enable && (wr_addr == read_addr0)) ? wr_data : regs_q[read_addr0];
    rd1_value = (wr_enable && (wr_addr == read_addr1)) ? wr_data : regs_q[read_addr1];
    // Only the pipeline can write while a debug read is in ACCESS, so bypass it alone here;
    // this also keeps the FSM's commit strobe out of its own input path.
    dbg_read_value = (reg_write_enable && (reg_write_addr == dbg_addr)) ? reg_write_data
                                                                       : regs_q[dbg_addr];
  end

  // Register array update; at most one write per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_enable) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Registered read ports, frozen while the operand-fetch stage stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data0_q <= '0;
      read_data1_q <= '0;
    end else if (!read_stall) begin
      read_data0_q <= rd0_value;
      read_data1_q <= rd1_value;
    end
  end

  assign read_data0 = read_data0_q;
  assign read_data1 = read_data1_q;

  processor_regfile_dbg #(
    .WORD_SIZE    (WORD_SIZE),
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_dbg (
    .clock            (clock),
    .reset            (reset),
    .dbg_req          (dbg_req),
    .dbg_we           (dbg_we),
    .dbg_addr         (dbg_addr),
    .dbg_wdata        (dbg_wdata),
    .pipe_write_enable(reg_write_enable),
    .read_value       (dbg_read_value),
    .dbg_ack          (dbg_ack),
    .dbg_rdata        (dbg_rdata),
    .commit_enable    (dbg_commit_enable),
    .commit_addr      (dbg_commit_addr),
    .commit_data      (dbg_commit_data)
  );

endmodule

// File: tb/tb_processor_regfile.sv
// Self-checking bench for processor_regfile: reference register model plus scoreboard queues
// for the read ports and the debug read result.
module tb_processor_regfile;

  localparam int unsigned W = 18;
  localparam int unsigned A = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         reg_write_enable;
  logic [A-1:0] reg_write_addr;
  logic [W-1:0] reg_write_data;
  logic         read_stall;
  logic [A-1:0] read_addr0, read_addr1;
  logic [W-1:0] read_data0, read_data1;
  logic         dbg_req, dbg_we;
  logic [A-1:0] dbg_addr;
  logic [W-1:0] dbg_wdata;
  logic         dbg_ack;
  logic [W-1:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model [8];
  logic [W-1:0] exp_rd0_q [$];
  logic [W-1:0] exp_rd1_q [$];
  logic [W-1:0] exp_dbg_q [$];
  logic [W-1:0] exp0, exp1, expd;

  always #5 clock = ~clock;

  processor_regfile dut (
    .clock           (clock),
    .reset           (reset),
    .reg_write_enable(reg_write_enable),
    .reg_write_addr  (reg_write_addr),
    .reg_write_data  (reg_write_data),
    .read_stall      (read_stall),
    .read_addr0      (read_addr0),
    .read_addr1      (read_addr1),
    .read_data0      (read_data0),
    .read_data1      (read_data1),
    .dbg_req         (dbg_req),
    .dbg_we          (dbg_we),
    .dbg_addr        (dbg_addr),
    .dbg_wdata       (dbg_wdata),
    .dbg_ack         (dbg_ack),
    .dbg_rdata       (dbg_rdata)
  );

  // One clock edge; the model follows pipeline writes and reset, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 8; i++) model[i] = '0;
    end else if (reg_write_enable) begin
      model[reg_write_addr] = reg_write_data;
    end
    #1;
  endtask

  // Expected read value for an address sampled this cycle (pipeline-write bypass only).
  function automatic logic [W-1:0] predict(input logic [A-1:0] a);
    if (!reset && reg_write_enable && (reg_write_addr == a)) return reg_write_data;
    return model[a];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reg_write_enable = 1'b1; reg_write_addr = 3'd4; reg_write_data = 18'h15555;
    tick();
    reg_write_enable = 1'b0;
    checks++; if (read_data0 !== '0) begin errors++; $display("FAIL reset_rd0 got=%h exp=0", read_data0); end
    checks++; if (read_data1 !== '0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", read_data1); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", dbg_ack); end
    checks++; if (dbg_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata); end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_addr0 = 3'(a); read_addr1 = 3'(7 - a);
      exp_rd0_q.push_back(predict(read_addr0));
      exp_rd1_q.push_back(predict(read_addr1));
      tick();
      exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
      checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL reset_read0 a=%0d got=%h exp=%h", a, read_data0, exp0); end
      checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL reset_read1 a=%0d got=%h exp=%h", 7 - a, read_data1, exp1); end
    end
    // Reset in the middle of a debug read: no ack, FSM back to IDLE.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd5;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL abort_pre got=%b exp=0", dbg_ack); end
    reset = 1'b1;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL abort_reset got=%b exp=0", dbg_ack); end
    reset = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL abort_noack c=%0d got=%b exp=0", i, dbg_ack); end
    end
    // Re-issue: IDLE -> ACCESS -> DONE proves the FSM restarted from IDLE.
    dbg_req = 1'b1;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reissue_access got=%b exp=0", dbg_ack); end
    exp_dbg_q.push_back(predict(dbg_addr));
    tick();
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL reissue_ack got=%b exp=1", dbg_ack); end
    expd = exp_dbg_q.pop_front();
    checks++; if (dbg_rdata !== expd) begin errors++; $display("FAIL reissue_rdata got=%h exp=%h", dbg_rdata, expd); end
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    reg_write_enable = 1'b1; reg_write_addr = 3'd3; reg_write_data = 18'h11111;
    read_addr0 = 3'd0; read_addr1 = 3'd1;
    tick();
    reg_write_data = 18'h2ABCD; read_addr0 = 3'd3; read_addr1 = 3'd3;
    exp_rd0_q.push_back(predict(read_addr0));
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    reg_write_enable = 1'b0;
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL bypass_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL bypass_rd1 got=%h exp=%h", read_data1, exp1); end
    read_addr1 = 3'd0;
    exp_rd0_q.push_back(predict(read_addr0));
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL bypass_after_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL bypass_after_rd1 got=%h exp=%h", read_data1, exp1); end
  endtask

  task automatic test_stall();
    reg_write_enable = 1'b1; reg_write_addr = 3'd5; reg_write_data = 18'h00123;
    read_addr0 = 3'd5; read_addr1 = 3'd3;
    exp_rd0_q.push_back(predict(read_addr0));
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    reg_write_enable = 1'b0;
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL stall_pre_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL stall_pre_rd1 got=%h exp=%h", read_data1, exp1); end
    read_stall = 1'b1; read_addr0 = 3'd0; read_addr1 = 3'd5;
    for (int i = 0; i < 2; i++) begin
      exp_rd0_q.push_back(exp0);
      exp_rd1_q.push_back(exp1);
      tick();
      exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
      checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL stall_hold_rd0 c=%0d got=%h exp=%h", i, read_data0, exp0); end
      checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL stall_hold_rd1 c=%0d got=%h exp=%h", i, read_data1, exp1); end
    end
    read_stall = 1'b0;
    exp_rd0_q.push_back(predict(read_addr0));
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL stall_rel_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL stall_rel_rd1 got=%h exp=%h", read_data1, exp1); end
  endtask

  task automatic test_dbg_write_conflict();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd2; dbg_wdata = 18'h3FFFF;
    reg_write_enable = 1'b1; reg_write_addr = 3'd6; reg_write_data = 18'h00A0A;
    read_addr0 = 3'd6; read_addr1 = 3'd2;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_busy0 got=%b exp=0", dbg_ack); end
    reg_write_addr = 3'd2; reg_write_data = 18'h01234;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_busy1 got=%b exp=0", dbg_ack); end
    reg_write_addr = 3'd6; reg_write_data = 18'h00B0B; read_addr0 = 3'd2; read_addr1 = 3'd6;
    exp_rd0_q.push_back(predict(read_addr0));
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_busy2 got=%b exp=0", dbg_ack); end
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL dbgw_nocommit_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL dbgw_pipe_rd1 got=%h exp=%h", read_data1, exp1); end
    // Port free: the debug write commits this cycle and the read port bypasses it.
    reg_write_enable = 1'b0;
    exp_rd0_q.push_back(dbg_wdata);
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    model[2] = 18'h3FFFF;
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dbgw_ack got=%b exp=1", dbg_ack); end
    exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL dbgw_bypass_rd0 got=%h exp=%h", read_data0, exp0); end
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL dbgw_bypass_rd1 got=%h exp=%h", read_data1, exp1); end
    dbg_req = 1'b0; dbg_we = 1'b0; read_addr1 = 3'd2;
    exp_rd1_q.push_back(predict(read_addr1));
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_ack_drop got=%b exp=0", dbg_ack); end
    exp1 = exp_rd1_q.pop_front();
    checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL dbgw_readback got=%h exp=%h", read_data1, exp1); end
  endtask

  task automatic test_dbg_read_bypass();
    int acks;
    reg_write_enable = 1'b1; reg_write_addr = 3'd7; reg_write_data = 18'h00055;
    tick();
    reg_write_enable = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd7;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgr_access got=%b exp=0", dbg_ack); end
    reg_write_enable = 1'b1; reg_write_data = 18'h00077;
    exp_dbg_q.push_back(predict(dbg_addr));
    acks = 0;
    tick();
    reg_write_enable = 1'b0;
    if (dbg_ack) acks++;
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dbgr_ack got=%b exp=1", dbg_ack); end
    expd = exp_dbg_q.pop_front();
    checks++; if (dbg_rdata !== expd) begin errors++; $display("FAIL dbgr_rdata got=%h exp=%h", dbg_rdata, expd); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dbg_ack) acks++;
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL dbgr_single_ack got=%0d exp=1", acks); end
    checks++; if (dbg_rdata !== expd) begin errors++; $display("FAIL dbgr_rdata_held got=%h exp=%h", dbg_rdata, expd); end
    dbg_req = 1'b0;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgr_idle got=%b exp=0", dbg_ack); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    reg_write_enable = 1'b1; reg_write_addr = 3'd1; reg_write_data = 18'h0BEEF;
    tick();
    reg_write_enable = 1'b0;
    for (int r = 0; r < 2; r++) begin
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = (r == 0) ? 3'd6 : 3'd1;
      exp_dbg_q.push_back(predict(dbg_addr));
      cyc = 0;
      while (!dbg_ack && cyc < 8) begin
        tick();
        cyc++;
      end
      checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_latency r=%0d got=%0d exp=2", r, cyc); end
      expd = exp_dbg_q.pop_front();
      checks++; if (dbg_rdata !== expd) begin errors++; $display("FAIL b2b_rdata r=%0d got=%h exp=%h", r, dbg_rdata, expd); end
      dbg_req = 1'b0;
      tick();
      checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL b2b_drop r=%0d got=%b exp=0", r, dbg_ack); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] last0, last1;
    last0 = '0; last1 = '0;
    for (int i = 0; i < 40; i++) begin
      reg_write_enable = 1'($urandom_range(0, 1));
      reg_write_addr   = 3'($urandom_range(0, 7));
      reg_write_data   = 18'($urandom);
      read_addr0       = 3'($urandom_range(0, 7));
      read_addr1       = 3'($urandom_range(0, 7));
      read_stall       = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      exp_rd0_q.push_back(read_stall ? last0 : predict(read_addr0));
      exp_rd1_q.push_back(read_stall ? last1 : predict(read_addr1));
      tick();
      exp0 = exp_rd0_q.pop_front(); exp1 = exp_rd1_q.pop_front();
      last0 = exp0; last1 = exp1;
      checks++; if (read_data0 !== exp0) begin errors++; $display("FAIL rand_rd0 i=%0d got=%h exp=%h", i, read_data0, exp0); end
      checks++; if (read_data1 !== exp1) begin errors++; $display("FAIL rand_rd1 i=%0d got=%h exp=%h", i, read_data1, exp1); end
    end
    reg_write_enable = 1'b0; read_stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    reg_write_enable = 1'b0; reg_write_addr = '0; reg_write_data = '0;
    read_stall = 1'b0; read_addr0 = '0; read_addr1 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    test_reset();
    test_bypass();
    test_stall();
    test_dbg_write_conflict();
    test_dbg_read_bypass();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
